mesh_input_unit: RTL and testbench
==================================

// Module: mesh_input_unit
// PURPOSE
//   Input side of one MESH router port; pairs with the switch controller. Buffers single-flit packets from the
//   upstream router and computes the XY output port for the head flit. Drives a one-hot output request into the
//   switch controller and pops the head on grant. Generates the valid/enable hold signal returned upstream.
// PARAMETERS
//   RADIX   5   router ports, fixed order [c,n,e,s,w] = bits 0..4
//   DEPTH   4   flit buffer depth, power of 2, >=2
//   DATA_W  32  flit width; dest X in [DATA_W-1 -: X_W], dest Y in the next Y_W bits below it
//   X_NODES 4   mesh width;  X_W = $clog2(X_NODES)
//   Y_NODES 4   mesh height; Y_W = $clog2(Y_NODES)
//   X_LOC   0   this router's X coordinate
//   Y_LOC   0   this router's Y coordinate
// PORTS
//   clk            in  1       single clock, rising edge
//   reset          in  1       asynchronous, active-high
//   i_data         in  DATA_W  flit from upstream
//   i_data_val     in  1       flit valid from upstream
//   o_en           out 1       enable to upstream: 1 = a flit may be sent this cycle
//   o_output_req   out RADIX   one-hot [c,n,e,s,w] request to the switch controller
//   i_output_grant in  RADIX   bit k = output k grants this input this cycle
//   o_data         out DATA_W  flit to crossbar, registered
//   o_data_val     out 1       o_data valid, registered
//   o_err          out 1       sticky error flag
// BEHAVIOUR
//   Reset: pointers/count = 0, o_en = 1, o_output_req = 0, o_data = 0, o_data_val = 0, o_err = 0. All in-flight
//     flits are discarded. Reset mid-transfer drops the buffer and any pending pop.
//   Buffer: circular, wr/rd pointers of $clog2(DEPTH) bits wrap from DEPTH-1 to 0; count has $clog2(DEPTH)+1 bits.
//   o_en = (count != DEPTH), decoded from registered count only; no combinational path from inputs.
//   Write: i_data_val && o_en -> store i_data at wr_ptr at the clock edge.
//     i_data_val && !o_en -> flit dropped, o_err set.
//   Route, combinational on head flit, only when count != 0 (else o_output_req = 0):
//     dx > X_LOC -> e (bit 2); dx < X_LOC -> w (bit 4);
//     dx == X_LOC: dy > Y_LOC -> s (bit 3); dy < Y_LOC -> n (bit 1); equal -> c (bit 0).
//   Request is held stable until a grant is received; it never changes while the same head is present.
//   Pop: (i_output_grant & o_output_req) != 0 -> rd_ptr++ at the edge.
//     o_data <= head and o_data_val <= 1 on the next edge (latency 1 from grant); otherwise o_data_val <= 0.
//     Any grant bit outside o_output_req -> ignored, o_err set.
//   Simultaneous write and pop: count unchanged, both pointers advance. A write when count == DEPTH cannot
//     coincide with a pop, because o_en is already 0 that cycle.
//   Fall-through latency: flit written at edge N -> request visible after edge N -> earliest o_data_val after
//     edge N+1.
//   Throughput: one flit per cycle in and out sustained when the grant is held.
//   o_err clears only on reset.
// TESTING
//   1 Reset: assert reset mid-stream with 3 flits buffered -> o_en=1, o_output_req=0, o_data_val=0,
//     count=0 immediately (async).
//   2 Routing at X_LOC=1, Y_LOC=1: dests (2,1),(0,1),(1,2),(1,0),(1,1) -> o_output_req = 00100, 00001,
//     00010, 01000, 10000 (MSB=bit0 c), one per head.
//   3 Fill: 4 writes with no grant -> o_en=0 after 4th edge; 5th i_data_val -> dropped, o_err=1;
//     one grant -> o_en=1 next cycle.
//   4 Streaming: continuous writes plus continuous matching grant -> o_data_val=1 every cycle,
//     flits in order, count stays 1.
//   5 Wrong grant: head requests e, grant=10000 (c) -> no pop, o_data_val=0, o_err=1, request unchanged.
//   6 Wrap: 10 flits through DEPTH=4 with random grant gaps -> output order equals input order, no loss.

Source files
------------

// File: rtl/mesh_input_unit.sv
// Input unit of one mesh router port: flit FIFO, XY route computation on the
// head flit, one-hot request to the switch controller and pop-on-grant.
module mesh_input_unit #(
  parameter int RADIX   = 5,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int X_LOC   = 0,
  parameter int Y_LOC   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_val,
  output logic              o_en,
  output logic [RADIX-1:0]  o_output_req,
  input  logic [RADIX-1:0]  i_output_grant,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_val,
  output logic              o_err
);

  localparam int X_W   = $clog2(X_NODES);
  localparam int Y_W   = $clog2(Y_NODES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Port order within the request vector
  localparam int P_C = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  localparam logic [X_W-1:0] X_HERE = X_W'(X_LOC);
  localparam logic [Y_W-1:0] Y_HERE = Y_W'(Y_LOC);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] data_reg;
  logic              data_val_reg;
  logic              err_reg;

  logic [DATA_W-1:0] head;
  logic [X_W-1:0]    dest_x;
  logic [Y_W-1:0]    dest_y;
  logic [RADIX-1:0]  route_req;
  logic              wr_en;
  logic              pop;
  logic              overflow;
  logic              bad_grant;

  // Enable depends only on the registered occupancy, never on inputs
  assign o_en      = (count_reg != CNT_W'(DEPTH));
  assign wr_en     = i_data_val && o_en;
  assign overflow  = i_data_val && !o_en;
  assign pop       = |(i_output_grant & route_req);
  assign bad_grant = |(i_output_grant & ~route_req);

  assign head   = mem[rd_ptr_reg];
  assign dest_x = head[DATA_W-1 -: X_W];
  assign dest_y = head[DATA_W-1-X_W -: Y_W];

  // XY routing: resolve X first, then Y; request only while a head exists.
  // The head only changes on a pop, so the request stays stable until granted.
  always_comb begin
    route_req = '0;
    if (count_reg != '0) begin
      if (dest_x > X_HERE)      route_req[P_E] = 1'b1;
      else if (dest_x < X_HERE) route_req[P_W] = 1'b1;
      else if (dest_y > Y_HERE) route_req[P_S] = 1'b1;
      else if (dest_y < Y_HERE) route_req[P_N] = 1'b1;
      else                      route_req[P_C] = 1'b1;
    end
  end

  assign o_output_req = route_req;

  // Flit storage: plain array without reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= i_data;
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered output stage: the popped head appears one cycle after grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg     <= '0;
      data_val_reg <= 1'b0;
    end else begin
      data_val_reg <= pop;
      if (pop) data_data_update: data_reg <= head;
    end
  end

  // Sticky error: overflow write or a grant bit that was never requested
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      err_reg <= 1'b0;
    else if (overflow || bad_grant) err_reg <= 1'b1;
  end

  assign o_data     = data_reg;
  assign o_data_val = data_val_reg;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_mesh_input_unit.sv
// Self-checking bench for mesh_input_unit at router (1,1): a queue-based
// reference model predicts enable, request, output flit and error flag.
module tb_mesh_input_unit;

  localparam int RADIX  = 5;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] i_data;
  logic              i_data_val;
  logic              o_en;
  logic [RADIX-1:0]  o_output_req;
  logic [RADIX-1:0]  i_output_grant;
  logic [DATA_W-1:0] o_data;
  logic              o_data_val;
  logic              o_err;

  mesh_input_unit #(
    .RADIX(RADIX), .DEPTH(DEPTH), .DATA_W(DATA_W),
    .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1)
  ) dut (
    .clk(clk), .reset(reset),
    .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_output_req(o_output_req), .i_output_grant(i_output_grant),
    .o_data(o_data), .o_data_val(o_data_val), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_data;
  logic              exp_val;
  logic              exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference XY routing for a router at (1,1); bit order c,n,e,s,w = 0..4
  function automatic logic [4:0] route(input logic [31:0] f);
    int dx = int'(f[31:30]);
    int dy = int'(f[29:28]);
    if (dx > 1) return 5'b00100;
    if (dx < 1) return 5'b10000;
    if (dy > 1) return 5'b01000;
    if (dy < 1) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic [4:0] exp_req();
    if (model_q.size() == 0) return 5'b0;
    return route(model_q[0]);
  endfunction

  function automatic logic [31:0] mk_flit(input int x, input int y);
    logic [31:0] f;
    f = $urandom();
    f[31:30] = 2'(x);
    f[29:28] = 2'(y);
    return f;
  endfunction

  // One clock cycle: drive at negedge, model at posedge, check at next negedge
  task automatic step(input logic [31:0] d, input logic v, input logic [4:0] g);
    logic       en_pre;
    logic [4:0] req_pre;
    i_data = d; i_data_val = v; i_output_grant = g;
    en_pre  = (model_q.size() != DEPTH);
    req_pre = exp_req();
    check("o_en", 32'(o_en), 32'(en_pre));
    check("o_output_req", 32'(o_output_req), 32'(req_pre));
    @(posedge clk);
    if ((g & req_pre) != 0) begin
      exp_data = model_q.pop_front();
      exp_val  = 1'b1;
    end else begin
      exp_val = 1'b0;
    end
    if ((g & ~req_pre) != 0) exp_err = 1'b1;
    if (v) begin
      if (en_pre) model_q.push_back(d);
      else        exp_err = 1'b1;
    end
    @(negedge clk);
    $display("cyc d=%08h v=%0b g=%05b -> val=%0b data=%08h err=%0b", d, v, g, o_data_val, o_data, o_err);
    check("o_data_val", 32'(o_data_val), 32'(exp_val));
    if (exp_val) check("o_data", o_data, exp_data);
    check("o_err", 32'(o_err), 32'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_o_en", 32'(o_en), 32'd1);
    check("rst_req", 32'(o_output_req), 32'd0);
    check("rst_val", 32'(o_data_val), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_data", o_data, 32'd0);
    model_q.delete();
    exp_val = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] f;
    reset = 1'b0; i_data = '0; i_data_val = 1'b0; i_output_grant = '0;
    exp_data = '0; exp_val = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    do_reset();

    // Routing: one head per destination, popped with its own request
    begin
      int xs[5] = '{2, 0, 1, 1, 1};
      int ys[5] = '{1, 1, 2, 0, 1};
      for (int i = 0; i < 5; i++) begin
        step(mk_flit(xs[i], ys[i]), 1'b1, 5'b0);
        check("route_req", 32'(o_output_req), 32'(route(model_q[0])));
        step('0, 1'b0, exp_req());
      end
    end

    // Fill to DEPTH, overflow, then free one slot
    for (int i = 0; i < DEPTH; i++) step(mk_flit($urandom_range(0, 3), $urandom_range(0, 3)), 1'b1, 5'b0);
    step(mk_flit(2, 2), 1'b1, 5'b0);
    step('0, 1'b0, exp_req());
    step('0, 1'b0, 5'b0);

    // Asynchronous reset with three flits buffered, mid-cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(mk_flit($urandom_range(0, 3), $urandom_range(0, 3)), 1'b1, 5'b0);
    #2;
    do_reset();

    // Streaming: write every cycle and grant the current head every cycle
    for (int i = 0; i < 12; i++) step(mk_flit($urandom_range(0, 3), $urandom_range(0, 3)), 1'b1, exp_req());
    step('0, 1'b0, exp_req());

    // Wrong grant: head requests east, grant offered on centre only
    do_reset();
    step(mk_flit(3, 0), 1'b1, 5'b0);
    step('0, 1'b0, 5'b00001);
    step('0, 1'b0, 5'b0);
    step('0, 1'b0, exp_req());

    // Random traffic with grant gaps through the wrapping buffer
    do_reset();
    for (int i = 0; i < 80; i++) begin
      f = mk_flit($urandom_range(0, 3), $urandom_range(0, 3));
      step(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0) ? exp_req() : 5'b0);
    end
    for (int i = 0; i < 8; i++) step('0, 1'b0, exp_req());
    check("drained", 32'(model_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
